// File: rtl/aes128_inv_round_ctrl.sv
// AES-128 block-decryption sequencer: owns the state register, walks round keys NR..0
// over a req/vld handshake and drives the shared inverse-round datapath. Optional AES_DEC_PERF_CNT_EN adds cyc_cnt.
module aes128_inv_round_ctrl #(
  parameter int unsigned NR     = 10,
  parameter int unsigned KIDX_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [127:0]      ct_in,
  output logic              busy,
  output logic              done,
  output logic [127:0]      pt_out,
  output logic              key_req,
  output logic [KIDX_W-1:0] key_idx,
  input  logic              key_vld,
  input  logic [127:0]      key_in,
  output logic [127:0]      dp_state,
  output logic [127:0]      dp_key,
  output logic [1:0]        dp_mode,
  input  logic [127:0]      dp_result
`ifdef AES_DEC_PERF_CNT_EN
  ,
  output logic [15:0]       cyc_cnt
`endif
);

  localparam logic [KIDX_W-1:0] NR_K = KIDX_W'(NR);

  typedef enum logic [2:0] {
    S_IDLE,
    S_KADD,
    S_RND,
    S_LAST,
    S_DONE
  } state_t;

  state_t              st, nxt;
  logic [127:0]        blk;
  logic [KIDX_W-1:0]   round, round_nxt;
  logic                load_ct, cap_state, cap_pt;

  always_ff @(posedge clk) begin
    if (rst) begin
      st     <= S_IDLE;
      blk    <= '0;
      round  <= '0;
      pt_out <= '0;
    end else begin
      st    <= nxt;
      round <= round_nxt;
      if (load_ct)
        blk <= ct_in;
      else if (cap_state)
        blk <= dp_result;
      if (cap_pt)
        pt_out <= dp_result;
    end
  end

  always_comb begin
    nxt       = st;
    round_nxt = round;
    key_req   = 1'b0;
    key_idx   = '0;
    dp_mode   = 2'd0;
    load_ct   = 1'b0;
    cap_state = 1'b0;
    cap_pt    = 1'b0;
    unique case (st)
      S_IDLE: begin
        if (start) begin
          load_ct   = 1'b1;
          round_nxt = NR_K;
          nxt       = S_KADD;
        end
      end
      S_KADD: begin
        key_req = 1'b1;
        key_idx = NR_K;
        dp_mode = 2'd0;
        if (key_vld) begin
          cap_state = 1'b1;
          round_nxt = NR_K - 1'b1;
          nxt       = S_RND;
        end
      end
      S_RND: begin
        key_req = 1'b1;
        key_idx = round;
        dp_mode = 2'd1;
        if (key_vld) begin
          cap_state = 1'b1;
          round_nxt = round - 1'b1;
          // exit on the round-1 capture so the counter never has to pass through zero
          nxt       = (round == KIDX_W'(1)) ? S_LAST : S_RND;
        end
      end
      S_LAST: begin
        key_req = 1'b1;
        key_idx = '0;
        dp_mode = 2'd2;
        if (key_vld) begin
          cap_pt = 1'b1;
          nxt    = S_DONE;
        end
      end
      S_DONE: begin
        nxt = S_IDLE;
      end
      default: begin
        nxt = S_IDLE;
      end
    endcase
  end

  assign busy     = (st != S_IDLE);
  assign done     = (st == S_DONE);
  assign dp_state = blk;
  assign dp_key   = key_in;

`ifdef AES_DEC_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst)
      cyc_cnt <= '0;
    else if (st == S_IDLE && start)
      cyc_cnt <= '0;
    else if (busy && cyc_cnt != '1)
      cyc_cnt <= cyc_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_aes128_inv_round_ctrl.sv
// Scoreboard bench for aes128_inv_round_ctrl with a reference inverse-round datapath
// and round-key store built from FIPS-197 key expansion.
module tb_aes128_inv_round_ctrl;

  localparam int NR = 10;
  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] ALT_CT = 128'hffffffffffffffffffffffffffffffff;

  logic         clk = 1'b0;
  logic         rst, start, key_vld;
  logic [127:0] ct_in, key_in, dp_state, dp_key, dp_result, pt_out;
  logic         busy, done, key_req;
  logic [3:0]   key_idx;
  logic [1:0]   dp_mode;
`ifdef AES_DEC_PERF_CNT_EN
  logic [15:0]  cyc_cnt;
`endif

  logic [7:0]   sbox [256];
  logic [7:0]   isbox[256];
  logic [127:0] rk   [16];

  int n_pass = 0;
  int n_chk  = 0;
  int cyc    = 0;
  logic [127:0] prev_pt = '0;

  typedef struct {
    logic [127:0] pt;
    int           lat;
    int           base;
  } exp_t;
  exp_t sb[$];

  aes128_inv_round_ctrl #(.NR(10), .KIDX_W(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .ct_in    (ct_in),
    .busy     (busy),
    .done     (done),
    .pt_out   (pt_out),
    .key_req  (key_req),
    .key_idx  (key_idx),
    .key_vld  (key_vld),
    .key_in   (key_in),
    .dp_state (dp_state),
    .dp_key   (dp_key),
    .dp_mode  (dp_mode),
    .dp_result(dp_result)
`ifdef AES_DEC_PERF_CNT_EN
    ,
    .cyc_cnt  (cyc_cnt)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [127:0] inv_round(input logic [127:0] s, input logic [127:0] k,
                                             input logic [1:0] m);
    logic [7:0]   a[16];
    logic [7:0]   b[16];
    logic [127:0] t;
    if (m == 2'd0) return s ^ k;
    for (int i = 0; i < 16; i++) a[i] = s[127-8*i -: 8];
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        b[c*4+r] = isbox[a[((c - r + 4) % 4)*4 + r]];
    for (int i = 0; i < 16; i++) t[127-8*i -: 8] = b[i];
    t = t ^ k;
    if (m == 2'd1) begin
      for (int i = 0; i < 16; i++) a[i] = t[127-8*i -: 8];
      for (int c = 0; c < 4; c++) begin
        b[c*4+0] = gmul(a[c*4], 8'd14) ^ gmul(a[c*4+1], 8'd11) ^ gmul(a[c*4+2], 8'd13) ^ gmul(a[c*4+3], 8'd9);
        b[c*4+1] = gmul(a[c*4], 8'd9)  ^ gmul(a[c*4+1], 8'd14) ^ gmul(a[c*4+2], 8'd11) ^ gmul(a[c*4+3], 8'd13);
        b[c*4+2] = gmul(a[c*4], 8'd13) ^ gmul(a[c*4+1], 8'd9)  ^ gmul(a[c*4+2], 8'd14) ^ gmul(a[c*4+3], 8'd11);
        b[c*4+3] = gmul(a[c*4], 8'd11) ^ gmul(a[c*4+1], 8'd13) ^ gmul(a[c*4+2], 8'd9)  ^ gmul(a[c*4+3], 8'd14);
      end
      for (int i = 0; i < 16; i++) t[127-8*i -: 8] = b[i];
    end
    return t;
  endfunction

  assign dp_result = inv_round(dp_state, dp_key, dp_mode);
  assign key_in    = rk[key_idx];

  task automatic build_sbox();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv, s;
      inv = '0;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
              ^ {inv[3:0], inv[7:4]} ^ 8'h63;
      sbox[x]  = s;
      isbox[s] = 8'(x);
    end
  endtask

  task automatic expand(input logic [127:0] key);
    logic [31:0] w[44];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]} ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 16; r++)
      rk[r] = (r <= NR) ? {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]} : '0;
  endtask

  // Monitor: every done pulse is matched against the oldest outstanding expectation.
`ifdef AES_DEC_PERF_CNT_EN
  logic cnt_pend = 1'b0;
  int   cnt_exp  = 0;
`endif
  always @(negedge clk) begin
`ifdef AES_DEC_PERF_CNT_EN
    if (cnt_pend) begin
      check("cyc_cnt", 128'(cyc_cnt), 128'(cnt_exp));
      cnt_pend = 1'b0;
    end
`endif
    if (done) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 128'(done), 128'(0));
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("pt_out", pt_out, e.pt);
        check("done_latency", 128'(cyc - e.base), 128'(e.lat));
`ifdef AES_DEC_PERF_CNT_EN
        cnt_pend = 1'b1;
        cnt_exp  = e.lat;
`endif
      end
    end
  end

  task automatic run(input logic [127:0] ct, input logic [127:0] pt, input bit pulse,
                     input int stall_idx, input int stall_len);
    int   base, rel, k, stalled;
    bit   got_done;
    exp_t e;
    @(negedge clk);
    start   = 1'b1;
    ct_in   = ct;
    key_vld = 1'b1;
    base    = cyc;
    e.pt = pt; e.lat = 12 + stall_len; e.base = base;
    sb.push_back(e);
    k        = NR;
    stalled  = 0;
    got_done = 1'b0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      rel   = cyc - base;
      start = pulse && (rel == 4 || rel == 12);
      if (start) ct_in = ALT_CT;
      if (rel == 1) check("pt_out_held", pt_out, prev_pt);
      if (k >= 0) begin
        check("busy", 128'(busy), 128'(1));
        check("key_req", 128'(key_req), 128'(1));
        check("key_idx", 128'(key_idx), 128'(k));
        check("dp_mode", 128'(dp_mode), 128'((k == NR) ? 0 : (k == 0) ? 2 : 1));
        if (k == stall_idx && stalled < stall_len) begin
          key_vld = 1'b0;
          stalled++;
        end else begin
          key_vld = 1'b1;
          k--;
        end
      end else if (done) begin
        got_done = 1'b1;
        break;
      end
    end
    if (!got_done) check("done_timeout", 128'(got_done), 128'(1));
    prev_pt = pt;
  endtask

  task automatic abort_run(input logic [127:0] ct);
    int base, rel;
    @(negedge clk);
    start   = 1'b1;
    ct_in   = ct;
    key_vld = 1'b1;
    base    = cyc;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      rel   = cyc - base;
      start = 1'b0;
      if (rel == 6) rst = 1'b1;
      if (rel == 7) begin
        rst = 1'b0;
        check("rst_busy", 128'(busy), 128'(0));
        check("rst_key_req", 128'(key_req), 128'(0));
        check("rst_pt_out", pt_out, '0);
        check("rst_dp_state", dp_state, '0);
        check("rst_key_idx", 128'(key_idx), 128'(0));
`ifdef AES_DEC_PERF_CNT_EN
        check("rst_cyc_cnt", 128'(cyc_cnt), 128'(0));
`endif
        break;
      end
    end
    prev_pt = '0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst     = 1'b1;
    start   = 1'b0;
    ct_in   = '0;
    key_vld = 1'b1;
    for (int r = 0; r < 16; r++) rk[r] = '0;
    build_sbox();
    expand(C1_KEY);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset_busy", 128'(busy), 128'(0));
    check("reset_done", 128'(done), 128'(0));
    check("reset_key_req", 128'(key_req), 128'(0));
    check("reset_key_idx", 128'(key_idx), 128'(0));
    check("reset_dp_mode", 128'(dp_mode), 128'(0));
    check("reset_pt_out", pt_out, '0);
    check("reset_dp_state", dp_state, '0);
`ifdef AES_DEC_PERF_CNT_EN
    check("reset_cyc_cnt", 128'(cyc_cnt), 128'(0));
`endif

    run(C1_CT, C1_PT, 1'b1, -1, 0);
    run(C1_CT, C1_PT, 1'b0, 5, 3);
    abort_run(C1_CT);
    expand(B_KEY);
    run(B_CT, B_PT, 1'b0, -1, 0);
    expand(C1_KEY);
    run(C1_CT, C1_PT, 1'b0, 2, 1);

    repeat (3) @(negedge clk);
    check("scoreboard_empty", 128'(sb.size()), 128'(0));
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
